// File: rtl/parking_display_scan.sv
// rtl/parking_display_scan.sv - Free-space count to BCD via double-dabble, scanned onto a 4-digit common-anode display.
module parking_display_scan #(
    parameter int DIGITS  = 4,
    parameter int VALUE_W = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               scan_tick_in,
    input  logic               blink_in,
    input  logic [VALUE_W-1:0] value,
    input  logic               full_flag,
    output logic [6:0]         seg,
    output logic [DIGITS-1:0]  an,
    output logic               busy
);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VALUE_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_next;
    logic               scan_s1, scan_s2, scan_d;
    logic               blink_s1, blink_s2;
    logic               scan_stb;
    logic [VALUE_W-1:0] sh;
    logic [VALUE_W-1:0] sat;
    logic [VALUE_W-1:0] last_value;
    logic [BCD_W-1:0]   scratch, adj;
    logic [BCD_W-1:0]   disp;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [DIGITS-1:0]  upper_nz;
    logic [3:0]         cur_digit;
    logic               show;
    logic               acc;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign scan_stb = scan_s2 & ~scan_d;
    assign busy     = (state != IDLE);
    assign sat      = (value > VALUE_W'(MAX_VAL)) ? VALUE_W'(MAX_VAL) : value;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_s1  <= 1'b0;
            scan_s2  <= 1'b0;
            scan_d   <= 1'b0;
            blink_s1 <= 1'b0;
            blink_s2 <= 1'b0;
        end else begin
            scan_s1  <= scan_tick_in;
            scan_s2  <= scan_s1;
            scan_d   <= scan_s2;
            blink_s1 <= blink_in;
            blink_s2 <= blink_s1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (value != last_value) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(VALUE_W - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sh         <= '0;
            scratch    <= '0;
            cnt        <= '0;
            last_value <= '0;
            disp       <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (value != last_value) begin
                        sh         <= sat;
                        last_value <= value;
                        scratch    <= '0;
                        cnt        <= '0;
                    end
                end
                SHIFT: begin
                    scratch <= {adj[BCD_W-2:0], sh[VALUE_W-1]};
                    sh      <= {sh[VALUE_W-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                end
                DONE:    disp <= scratch;
                default: ;
            endcase
        end
    end

    // upper_nz[k] is set when any digit at position k or above is non-zero.
    always_comb begin
        acc       = 1'b0;
        upper_nz  = '0;
        cur_digit = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc         = acc | (|disp[4*k +: 4]);
            upper_nz[k] = acc;
            if (IDX_W'(k) == idx) cur_digit = disp[4*k +: 4];
        end
        show = ((idx == '0) || upper_nz[idx]) && !(full_flag && !blink_s2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
            seg <= 7'h7F;
            an  <= '1;
        end else begin
            if (scan_stb) idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            seg <= show ? decode(cur_digit) : 7'h7F;
            an  <= show ? ~(DIGITS'(1) << idx) : '1;
        end
    end
endmodule

// File: tb/tb_parking_display_scan.sv
// tb/tb_parking_display_scan.sv - Table-driven and randomized checks of parking_display_scan.
module tb_parking_display_scan;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        scan_tick_in;
    logic        blink_in;
    logic [13:0] value;
    logic        full_flag;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int midx   = 0;

    typedef struct {
        int             v;
        bit             full;
        bit             blk;
        logic [0:3][3:0] exp_an;
        logic [0:3][6:0] exp_seg;
    } vec_t;

    vec_t       tbl[$];
    logic [6:0] seg_tab [10];
    logic       busy_r [40];
    logic [6:0] seg_r  [40];

    always #5 clk = ~clk;

    parking_display_scan dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .scan_tick_in (scan_tick_in),
        .blink_in     (blink_in),
        .value        (value),
        .full_flag    (full_flag),
        .seg          (seg),
        .an           (an),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_pulse();
        scan_tick_in = 1'b1;
        tick(5);
        scan_tick_in = 1'b0;
        tick(5);
        midx = (midx + 1) % 4;
    endtask

    function automatic logic [3:0] model_an(input int v, input int k, input bit full, input bit blk);
        int s = (v > 9999) ? 9999 : v;
        int p = 10 ** k;
        if (full && !blk) return 4'hF;
        if (k > 0 && s < p) return 4'hF;
        return ~(4'b0001 << k);
    endfunction

    function automatic logic [6:0] model_seg(input int v, input int k, input bit full, input bit blk);
        int s = (v > 9999) ? 9999 : v;
        int p = 10 ** k;
        if (full && !blk) return 7'h7F;
        if (k > 0 && s < p) return 7'h7F;
        return seg_tab[(s / p) % 10];
    endfunction

    task automatic apply(input int v, input bit full, input bit blk);
        value     = 14'(v);
        full_flag = full;
        blink_in  = blk;
        tick(25);
    endtask

    task automatic check_model(input string name, input int v, input bit full, input bit blk);
        for (int s = 0; s < 4; s++) begin
            chk({name, "_an"}, 16'(an), 16'(model_an(v, midx, full, blk)));
            chk({name, "_seg"}, 16'(seg), 16'(model_seg(v, midx, full, blk)));
            scan_pulse();
        end
    endtask

    task automatic do_reset(input int v);
        reset_n = 1'b0;
        value   = 14'(v);
        tick(3);
        reset_n = 1'b1;
        midx    = 0;
    endtask

    task automatic record(input int change_at, input int new_v);
        @(posedge clk);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            busy_r[j] = busy;
            seg_r[j]  = seg;
            if (j == change_at) value = 14'(new_v);
        end
    endtask

    initial begin
        int nbusy;
        int v;
        bit f, b;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

        tbl.push_back('{1234, 1'b0, 1'b0, {4'b1110, 4'b1101, 4'b1011, 4'b0111},
                        {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}});
        tbl.push_back('{7, 1'b0, 1'b0, {4'b1110, 4'b1111, 4'b1111, 4'b1111},
                        {7'b1111000, 7'h7F, 7'h7F, 7'h7F}});
        tbl.push_back('{1005, 1'b0, 1'b0, {4'b1110, 4'b1101, 4'b1011, 4'b0111},
                        {7'b0010010, 7'b1000000, 7'b1000000, 7'b1111001}});
        tbl.push_back('{12000, 1'b0, 1'b0, {4'b1110, 4'b1101, 4'b1011, 4'b0111},
                        {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}});
        tbl.push_back('{42, 1'b1, 1'b0, {4'b1111, 4'b1111, 4'b1111, 4'b1111},
                        {7'h7F, 7'h7F, 7'h7F, 7'h7F}});
        tbl.push_back('{42, 1'b1, 1'b1, {4'b1110, 4'b1101, 4'b1111, 4'b1111},
                        {7'b0100100, 7'b0011001, 7'h7F, 7'h7F}});
        tbl.push_back('{42, 1'b0, 1'b0, {4'b1110, 4'b1101, 4'b1111, 4'b1111},
                        {7'b0100100, 7'b0011001, 7'h7F, 7'h7F}});
        tbl.push_back('{0, 1'b0, 1'b1, {4'b1110, 4'b1111, 4'b1111, 4'b1111},
                        {7'b1000000, 7'h7F, 7'h7F, 7'h7F}});

        reset_n      = 1'b0;
        scan_tick_in = 1'b0;
        blink_in     = 1'b0;
        full_flag    = 1'b0;
        value        = '0;
        tick(3);
        chk("reset_an", 16'(an), 16'hF);
        chk("reset_seg", 16'(seg), 16'h7F);
        chk("reset_busy", 16'(busy), 16'h0);
        reset_n = 1'b1;
        midx    = 0;
        tick(3);
        chk("idle_busy", 16'(busy), 16'h0);
        for (int s = 0; s < 4; s++) begin
            chk("zero_an", 16'(an), (midx == 0) ? 16'hE : 16'hF);
            chk("zero_seg", 16'(seg), (midx == 0) ? 16'h40 : 16'h7F);
            scan_pulse();
        end

        // 0 -> 1234: busy exactly 15 cycles, visible digit changes on edge 16.
        value = 14'd1234;
        record(-1, 0);
        nbusy = 0;
        for (int j = 0; j < 15; j++) nbusy += busy_r[j];
        chk("busy_len", 16'(nbusy), 16'd15);
        chk("busy_end", 16'(busy_r[15]), 16'd0);
        chk("seg_old_e15", 16'(seg_r[15]), 16'h40);
        chk("seg_new_e16", 16'(seg_r[16]), 16'(7'b0011001));

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].full, tbl[i].blk);
            for (int s = 0; s < 4; s++) begin
                chk($sformatf("tbl%0d_an", i), 16'(an), 16'(tbl[i].exp_an[midx]));
                chk($sformatf("tbl%0d_seg", i), 16'(seg), 16'(tbl[i].exp_seg[midx]));
                scan_pulse();
            end
        end

        for (int n = 0; n < 16; n++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 16383));
            f = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            apply(v, f, b);
            check_model($sformatf("rnd%0d", n), v, f, b);
        end

        // 1234 -> 5678 changed during busy cycle 5.
        full_flag = 1'b0;
        do_reset(0);
        tick(3);
        value = 14'd1234;
        record(4, 5678);
        chk("mid_busy_e15", 16'(busy_r[15]), 16'd0);
        chk("mid_busy_e16", 16'(busy_r[16]), 16'd1);
        chk("mid_busy_e30", 16'(busy_r[30]), 16'd1);
        chk("mid_busy_e31", 16'(busy_r[31]), 16'd0);
        chk("mid_seg_e15", 16'(seg_r[15]), 16'h40);
        chk("mid_seg_e16", 16'(seg_r[16]), 16'(7'b0011001));
        chk("mid_seg_e31", 16'(seg_r[31]), 16'(7'b0011001));
        chk("mid_seg_e32", 16'(seg_r[32]), 16'(7'b0000000));
        tick(5);
        check_model("mid_final", 5678, 1'b0, 1'b0);

        // Reset asserted mid-SHIFT, then reconversion of the held value.
        value = 14'd1111;
        tick(5);
        chk("rs_busy_pre", 16'(busy), 16'd1);
        reset_n = 1'b0;
        #1;
        chk("rs_busy", 16'(busy), 16'd0);
        chk("rs_an", 16'(an), 16'hF);
        chk("rs_seg", 16'(seg), 16'h7F);
        tick(2);
        reset_n = 1'b1;
        midx    = 0;
        tick(1);
        chk("rs_restart_busy", 16'(busy), 16'd1);
        tick(20);
        check_model("rs_final", 1111, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/parking_display_scan.md
Name: parking_display_scan

Overview:
- Downstream consumer of the clock divider's 500 Hz and 2 Hz outputs.
- Converts the binary free-space count into BCD using a sequential double-dabble FSM.
- Time-multiplexes the BCD digits onto a common-anode 7-segment display, with leading-zero blanking and a 2 Hz blink when the lot is full.
- Single clock domain: the divider outputs are sampled as data and never used as clocks.

Parameters:
- DIGITS, 4, number of multiplexed digits (fixed at 4 for this revision).
- VALUE_W, 14, width of the binary input value.
- MAX_VAL, 9999, saturation ceiling for the displayed value.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- scan_tick_in  in  1  500 Hz square wave from the divider (clk_500Hz)
- blink_in  in  1  2 Hz square wave from the divider (clk_2Hz)
- value  in  VALUE_W  binary free-space count
- full_flag  in  1  lot full; enables blinking
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an  out  DIGITS  digit enables, active-low, one-hot-low while scanning
- busy  out  1  BCD conversion in progress

Behaviour:
- Reset is asynchronous on reset_n low. It sets:
  - seg=7'h7F, an=all 1s, busy=0.
  - digit index=0, display BCD registers=0, last_value=0, FSM=IDLE.
  - Both synchronizers cleared.
- Reset mid-conversion aborts the conversion and discards the scratch result.
- Input conditioning:
  - scan_tick_in and blink_in each pass through a 2-FF synchronizer.
  - scan_stb is a 1-clk pulse on a rising edge of the synchronized scan_tick.
  - blink_on is the synchronized blink level.
- BCD FSM states: IDLE, SHIFT, DONE.
  - IDLE: if value != last_value, latch sat = min(value, MAX_VAL) into the shift register, latch last_value=value, clear the BCD scratch, go to SHIFT.
  - SHIFT: VALUE_W cycles. Each cycle, add 3 to any scratch nibble >=5, then shift left 1 with the MSB of the shift register entering the scratch.
  - DONE: copy the scratch to the display registers atomically, go to IDLE.
  - busy=1 in SHIFT and DONE: exactly VALUE_W+1 = 15 cycles.
  - The display updates VALUE_W+2 = 16 clk edges after the edge that latched the value.
  - value changes while busy are ignored. On return to IDLE the compare re-triggers if value still differs from last_value.
  - After reset with value!=0, a conversion starts on the first clk edge.
- Scanner:
  - The digit index increments on each scan_stb and wraps DIGITS-1 -> 0.
  - Digit 0 is the least significant.
- Blanking: digit k>0 is blank when it and all higher digits are 0. Digit 0 is never blanked.
- Blink: when full_flag=1 and blink_on=0, all digits are off.
- Output logic:
  - A digit that is not blanked and not blinked off drives an[idx]=0 with the other an bits 1, and seg = that digit's decode.
  - Otherwise an=all 1s and seg=7'h7F.
  - seg and an are registered and lag the index/BCD state by 1 clk.
- Segment decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- A scan_stb during a conversion is honoured and shows the old display registers.

Test Plan:
- Reset: hold reset_n=0 with value=0 -> an=4'b1111, seg=7'b1111111, busy=0. Release, pulse scan_tick 4 times -> an=1110/seg=1000000 only at idx 0; blank at idx 1-3.
- value=1234: busy=1 for 15 cycles, display updates on the 16th edge. Then 4 scan ticks -> (an,seg) = (1110,0011001), (1101,0110000), (1011,0100100), (0111,1111001).
- value=7: idx 0 shows 1111000; idx 1-3 -> an=1111. value=1005: idx 2 shows '0' (1000000) because it is not a leading zero.
- value=12000 -> saturates; all four digits show 9 (0010000).
- full_flag=1, value=42: blink_in low >=3 clks -> an=1111 at every idx; blink_in high -> normal scan resumes. full_flag=0 -> blink_in is ignored.
- Mid-conversion events:
  - value 1234 -> 5678 at busy cycle 5: 1234 is displayed first, then busy re-asserts the cycle after DONE, and 5678 appears 16 edges later.
  - reset_n pulsed low mid-SHIFT: display=0 and busy=0 immediately; reconversion starts after release.
